// File: rtl/c16_mem_pkg.sv
// Shared types and defaults for the C16 memory arbiter.
package c16_mem_pkg;
  localparam int C16_ADDR_W     = 16;
  localparam int C16_DATA_W     = 16;
  localparam int MAX_RD_LATENCY = 3;

  typedef enum logic [1:0] {
    REQ_FETCH = 2'd0,
    REQ_DATA  = 2'd1,
    REQ_DEBUG = 2'd2,
    REQ_NONE  = 2'd3
  } req_id_e;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating denied-cycle counter; at_limit_o marks a requester as starved.
module arb_starve_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         at_limit_o
);
  logic [W-1:0] cnt_q;

  assign at_limit_o = (cnt_q >= limit_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       cnt_q <= '0;
    else if (clr_i)                     cnt_q <= '0;
    else if (inc_i && cnt_q < limit_i)  cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority RAM port arbiter (fetch > data > debug) with starvation promotion
// and tagged read return. Define MEM_ARB_STATS_EN to add grant/conflict counters.
module mem_arbiter
  import c16_mem_pkg::*;
#(
  parameter int ADDR_W       = C16_ADDR_W,
  parameter int DATA_W       = C16_DATA_W,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              fetch_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_fetch_gnts,
  output logic [15:0]       stat_data_gnts,
  output logic [15:0]       stat_dbg_gnts,
  output logic [15:0]       stat_conflicts
`endif
);
  localparam int CW = $clog2(2 * STARVE_LIMIT + 1);

  logic    data_at_lim, dbg_at_lim;
  logic    data_starved, dbg_starved;
  req_id_e push_tag;
  req_id_e tag_q [RD_LATENCY];

  arb_starve_ctr #(.W(CW)) u_data_starve (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (data_req && !data_gnt),
    .clr_i      (data_gnt || !data_req),
    .limit_i    (CW'(STARVE_LIMIT)),
    .at_limit_o (data_at_lim)
  );

  arb_starve_ctr #(.W(CW)) u_dbg_starve (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (dbg_req && !dbg_gnt),
    .clr_i      (dbg_gnt || !dbg_req),
    .limit_i    (CW'(2 * STARVE_LIMIT)),
    .at_limit_o (dbg_at_lim)
  );

  assign data_starved = data_req && data_at_lim;
  assign dbg_starved  = dbg_req && dbg_at_lim;

  // Grant and RAM mux share one priority chain so they cannot disagree.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    dbg_gnt   = 1'b0;
    if (dbg_starved && !data_starved) dbg_gnt   = 1'b1;
    else if (data_starved)            data_gnt  = 1'b1;
    else if (fetch_req)               fetch_gnt = 1'b1;
    else if (data_req)                data_gnt  = 1'b1;
    else if (dbg_req)                 dbg_gnt   = 1'b1;
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    push_tag  = REQ_NONE;
    if (fetch_gnt) begin
      ram_addr = fetch_addr;
      push_tag = REQ_FETCH;
    end else if (data_gnt) begin
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
      ram_wren  = data_we && reset_n;
      push_tag  = data_we ? REQ_NONE : REQ_DATA;
    end else if (dbg_gnt) begin
      ram_addr = dbg_addr;
      push_tag = REQ_DEBUG;
    end
  end

  assign fetch_stall = fetch_req && !fetch_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= REQ_NONE;
    end else begin
      tag_q[0] <= push_tag;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign fetch_rvalid = (tag_q[RD_LATENCY-1] == REQ_FETCH);
  assign data_rvalid  = (tag_q[RD_LATENCY-1] == REQ_DATA);
  assign dbg_rvalid   = (tag_q[RD_LATENCY-1] == REQ_DEBUG);
  assign rdata        = ram_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] st_fetch_q, st_data_q, st_dbg_q, st_conf_q;
  logic        conflict;

  assign conflict = (fetch_req && data_req) || (fetch_req && dbg_req) || (data_req && dbg_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_fetch_q <= '0;
      st_data_q  <= '0;
      st_dbg_q   <= '0;
      st_conf_q  <= '0;
    end else begin
      st_fetch_q <= st_fetch_q + 16'(fetch_gnt);
      st_data_q  <= st_data_q + 16'(data_gnt);
      st_dbg_q   <= st_dbg_q + 16'(dbg_gnt);
      st_conf_q  <= st_conf_q + 16'(conflict);
    end
  end

  assign stat_fetch_gnts = st_fetch_q;
  assign stat_data_gnts  = st_data_q;
  assign stat_dbg_gnts   = st_dbg_q;
  assign stat_conflicts  = st_conf_q;
`endif
endmodule
